// File: rtl/ibex_counter_bank.sv
`timescale 1ns/1ps
// ibex_counter_bank: memory-mapped bank of 32-bit event counters with enable, sticky overflow and overflow interrupt.
// Ports: clk_i/rst_i (async active-high reset); counter_req_i/gnt_o/rvalid_o/we_i/addr_i/wdata_i/rdata_o/err_o
// form a req/gnt bus with one-cycle response; event_i[i] increments counter i when enabled; ovf_irq_o is the
// overflow interrupt. Define IBEX_COUNTER_BANK_OVF_IRQ_EN to implement the OVF register and ovf_irq_o.
module ibex_counter_bank #(
  parameter int unsigned NUM_COUNTERS = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0002_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    counter_req_i,
  output logic                    counter_gnt_o,
  output logic                    counter_rvalid_o,
  input  logic                    counter_we_i,
  input  logic [31:0]             counter_addr_i,
  input  logic [31:0]             counter_wdata_i,
  output logic [31:0]             counter_rdata_o,
  output logic                    counter_err_o,
  input  logic [NUM_COUNTERS-1:0] event_i,
  output logic                    ovf_irq_o
);
  typedef enum logic {IDLE, RESP} state_e;
  state_e                  state_q, state_d;
  logic                    gnt;
  logic [31:0]             cnt_q [NUM_COUNTERS];
  logic [31:0]             cnt_d [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] ctrl_q, ctrl_d, ovf_q, inc, wr_cnt;
  logic [31:0]             rdata_q, rdata_d, cnt_rd, rd_val;
  logic                    err_q, err_d;
  logic [7:0]              off;
  logic [4:0]              idx;
  logic                    hit, is_cnt, is_ctrl, is_ovf, dec_err, wr_ok;
  assign off     = counter_addr_i[7:0];
  assign idx     = off[6:2];
  assign hit     = counter_addr_i[31:8] == BASE_ADDR[31:8];
  assign is_cnt  = hit && !off[7] && off[1:0] == 2'b00 && 6'(idx) < 6'(NUM_COUNTERS);
  assign is_ctrl = hit && off == 8'h80;
  assign is_ovf  = hit && off == 8'h84;
  assign dec_err = !(is_cnt || is_ctrl || is_ovf);
  assign wr_ok   = gnt && counter_we_i && !dec_err;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end
  always_comb state_d = gnt ? RESP : IDLE;
  always_comb begin
    gnt              = counter_req_i && !rst_i;
    counter_gnt_o    = gnt;
    counter_rvalid_o = state_q == RESP;
    counter_rdata_o  = rdata_q;
    counter_err_o    = err_q;
  end
  // Read data is taken from the current register values, i.e. before this cycle's increment.
  always_comb begin
    cnt_rd = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) if (idx == 5'(i)) cnt_rd = cnt_q[i];
    rd_val  = is_cnt ? cnt_rd : is_ctrl ? 32'(ctrl_q) : is_ovf ? 32'(ovf_q) : '0;
    rdata_d = gnt ? ((counter_we_i || dec_err) ? '0 : rd_val) : rdata_q;
    err_d   = gnt ? dec_err : err_q;
  end
  // A bus write to a counter takes priority over its increment in the same cycle.
  always_comb begin
    inc    = '0;
    wr_cnt = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      inc[i]    = event_i[i] && ctrl_q[i];
      wr_cnt[i] = wr_ok && is_cnt && idx == 5'(i);
      cnt_d[i]  = wr_cnt[i] ? counter_wdata_i : cnt_q[i] + 32'(inc[i]);
    end
    ctrl_d = (wr_ok && is_ctrl) ? counter_wdata_i[NUM_COUNTERS-1:0] : ctrl_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_COUNTERS; i++) cnt_q[i] <= '0;
      ctrl_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
`ifdef IBEX_COUNTER_BANK_OVF_IRQ_EN
  logic [NUM_COUNTERS-1:0] ovf_set, ovf_clr, ovf_d;
  logic                    irq_q;
  // A new overflow beats a coincident write-1-to-clear, so the event is never lost.
  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) ovf_set[i] = inc[i] && !wr_cnt[i] && &cnt_q[i];
    ovf_clr = (wr_ok && is_ovf) ? counter_wdata_i[NUM_COUNTERS-1:0] : '0;
    ovf_d   = (ovf_q & ~ovf_clr) | ovf_set;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      irq_q <= |ovf_q;
    end
  end
  assign ovf_irq_o = irq_q;
`else
  assign ovf_q     = '0;
  assign ovf_irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_ibex_counter_bank.sv
`timescale 1ns/1ps
// tb_ibex_counter_bank: scoreboard bench for the counter bank bus, counting, overflow and reset behaviour.
module tb_ibex_counter_bank;
  localparam logic [31:0] B = 32'h0002_0000;
`ifdef IBEX_COUNTER_BANK_OVF_IRQ_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif
  localparam logic [31:0] OVF4 = OVF_ON ? 32'h4 : 32'h0;
  logic clk = 1'b0, rst = 1'b1, req = 1'b1, we = 1'b0, gnt, rvalid, err, irq;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [7:0] ev = '0;
  typedef struct {logic [31:0] d; logic e; int due; string nm;} exp_t;
  exp_t q[$];
  exp_t mx;
  int cyc = 0, n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ibex_counter_bank dut (
    .clk_i(clk), .rst_i(rst), .counter_req_i(req), .counter_gnt_o(gnt), .counter_rvalid_o(rvalid),
    .counter_we_i(we), .counter_addr_i(addr), .counter_wdata_i(wdata), .counter_rdata_o(rdata),
    .counter_err_o(err), .event_i(ev), .ovf_irq_o(irq)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_rvalid: got no response expected one in cycle %0d", q[0].nm, q[0].due);
      void'(q.pop_front());
    end
    if (rvalid) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL stray_rvalid: got rvalid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        mx = q.pop_front();
        chk({mx.nm, "_rdata"}, rdata, mx.d);
        chk({mx.nm, "_err"}, 32'(err), 32'(mx.e));
        chk({mx.nm, "_cycle"}, cyc, mx.due);
      end
    end
  end
  task automatic acc(input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_d, input bit exp_e, input string nm);
    req = 1'b1; we = w; addr = a; wdata = wd;
    #1 chk({nm, "_gnt"}, 32'(gnt), 32'd1);
    q.push_back('{d: exp_d, e: exp_e, due: cyc + 1, nm: nm});
    @(posedge clk);
    #1 req = 1'b0;
  endtask
  initial begin
    #2;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_irq", 32'(irq), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; req = 1'b0;
    acc(1, B + 32'h04, 32'h5, 0, 0, "wr_cnt1");
    acc(0, B + 32'h04, 0, 32'h5, 0, "rd_cnt1");
    acc(1, B + 32'h80, 32'h1, 0, 0, "wr_ctrl1");
    ev = 8'h03;
    repeat (10) @(posedge clk);
    #1 ev = '0;
    acc(0, B + 32'h00, 0, 32'd10, 0, "rd_cnt0_10");
    acc(0, B + 32'h04, 0, 32'h5, 0, "rd_cnt1_disabled");
    acc(1, B + 32'h08, 32'hFFFF_FFFE, 0, 0, "wr_cnt2");
    acc(1, B + 32'h80, 32'h4, 0, 0, "wr_ctrl4");
    ev = 8'h04;
    repeat (2) @(posedge clk);
    #1 ev = '0;
    acc(0, B + 32'h08, 0, 0, 0, "rd_cnt2_wrapped");
    acc(0, B + 32'h84, 0, OVF4, 0, "rd_ovf_set");
    chk("irq_set", 32'(irq), 32'(OVF_ON));
    acc(1, B + 32'h84, 32'h4, 0, 0, "w1c_ovf");
    acc(0, B + 32'h84, 0, 0, 0, "rd_ovf_cleared");
    chk("irq_clear", 32'(irq), 0);
    acc(0, B + 32'h02, 0, 0, 1, "err_misaligned");
    acc(0, B + 32'h40, 0, 0, 1, "err_cnt_idx");
    acc(0, 32'h0003_0000, 0, 0, 1, "err_base");
    acc(0, B + 32'h88, 0, 0, 1, "err_unmapped");
    acc(1, B + 32'h02, 32'h123, 0, 1, "err_wr_misaligned");
    acc(1, B + 32'h20, 32'h456, 0, 1, "err_wr_idx");
    acc(0, B + 32'h00, 0, 32'd10, 0, "rd_cnt0_untouched");
    acc(1, B + 32'h08, 32'hFFFF_FFFF, 0, 0, "wr_cnt2_max");
    ev = 8'h04;
    acc(1, B + 32'h08, 32'h100, 0, 0, "wr_cnt2_vs_inc");
    ev = '0;
    acc(0, B + 32'h08, 0, 32'h100, 0, "rd_cnt2_written");
    acc(0, B + 32'h84, 0, 0, 0, "rd_ovf_no_set");
    acc(1, B + 32'h08, 32'hFFFF_FFFF, 0, 0, "wr_cnt2_max2");
    ev = 8'h04;
    acc(1, B + 32'h84, 32'h4, 0, 0, "w1c_vs_ovf");
    ev = '0;
    acc(0, B + 32'h84, 0, OVF4, 0, "rd_ovf_kept");
    acc(0, B + 32'h08, 0, 0, 0, "rd_cnt2_wrap2");
    acc(1, B + 32'h84, 32'h4, 0, 0, "w1c_ovf2");
    acc(0, B + 32'h84, 0, 0, 0, "rd_ovf_cleared2");
    acc(1, B + 32'h80, 32'hFFFF_FFFF, 0, 0, "wr_ctrl_all");
    acc(0, B + 32'h80, 0, 32'hFF, 0, "rd_ctrl_upper");
    acc(1, B + 32'h84, 32'hFFFF_FFFF, 0, 0, "w1c_all");
    acc(0, B + 32'h84, 0, 0, 0, "rd_ovf_upper");
    acc(1, B + 32'h80, 32'h0, 0, 0, "wr_ctrl0");
    acc(0, B + 32'h00, 0, 32'd10, 0, "b2b_cnt0");
    acc(0, B + 32'h04, 0, 32'h5, 0, "b2b_cnt1");
    acc(0, B + 32'h00, 0, 32'd10, 0, "pre_rst_rd");
    req = 1'b1; we = 1'b0; addr = B + 32'h04; rst = 1'b1;
    q.delete();
    #1 chk("rst_pulse_gnt", 32'(gnt), 0);
    chk("rst_pulse_rvalid", 32'(rvalid), 0);
    @(posedge clk);
    #1 rst = 1'b0; req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    acc(0, B + 32'h00, 0, 0, 0, "post_rst_cnt0");
    acc(0, B + 32'h04, 0, 0, 0, "post_rst_cnt1");
    acc(0, B + 32'h08, 0, 0, 0, "post_rst_cnt2");
    acc(0, B + 32'h80, 0, 0, 0, "post_rst_ctrl");
    acc(0, B + 32'h84, 0, 0, 0, "post_rst_ovf");
    chk("post_rst_irq", 32'(irq), 0);
    repeat (3) @(posedge clk);
    #1 chk("queue_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1);
  end
endmodule
